mem_block_adapter: RTL and testbench

- Sits directly downstream of the cache controller, between its block-wide memory request port and a word-wide main-memory bus.
- On a write-back, serialises one 512-bit evicted block into 16 sequential 32-bit write beats.
- On a refill, issues 16 read beats and assembles the returned words into one 512-bit block for the controller.
- Each block transfer is a single request/ready handshake on the cache side.

---
 rtl/mem_adapter_pkg.sv | 17 +
 rtl/mem_beat_counter.sv | 38 +++
 rtl/mem_block_adapter.sv | 163 ++++++++++++++++
 tb/tb_mem_block_adapter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_adapter_pkg.sv
// Shared constants and FSM state type for the block-to-word memory adapter.
package mem_adapter_pkg;

  localparam int unsigned WORD_SIZE_DEF        = 32;
  localparam int unsigned BLOCK_OFFSET_DEF     = 4;
  localparam int unsigned BLOCK_DATA_WIDTH_DEF = WORD_SIZE_DEF << BLOCK_OFFSET_DEF;
  localparam int unsigned WORDS_PER_BLOCK      = 32'd1 << BLOCK_OFFSET_DEF;
  localparam int unsigned LAST_BEAT            = WORDS_PER_BLOCK - 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2,
    DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/mem_beat_counter.sv
// Beat offset counter: loadable start offset, wraps modulo the block size,
// and flags the beat that completes a full block.
module mem_beat_counter
  import mem_adapter_pkg::*;
#(
  parameter int unsigned OFFSET_W = BLOCK_OFFSET_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [OFFSET_W-1:0] start_off,
  input  logic                inc,
  output logic [OFFSET_W-1:0] offset,
  output logic                last_c
);

  localparam logic [OFFSET_W-1:0] LAST = OFFSET_W'((32'd1 << OFFSET_W) - 32'd1);

  logic [OFFSET_W-1:0] beats_q;

  // Current beat is the final one of the block once 15 beats have been acked.
  assign last_c = (beats_q == LAST);

  // Offset and completed-beat count; load restarts both for a new burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset  <= '0;
      beats_q <= '0;
    end else if (load) begin
      offset  <= start_off;
      beats_q <= '0;
    end else if (inc) begin
      offset  <= offset + OFFSET_W'(1);
      beats_q <= beats_q + OFFSET_W'(1);
    end
  end

endmodule

// File: rtl/mem_block_adapter.sv
// Block-wide cache request port to word-wide memory bus adapter.
// Write-backs serialise a block into word write beats; refills gather read
// beats into a block. Optional MEM_CRITICAL_WORD_FIRST_EN starts refills at
// the requested word offset and wraps through the block.
module mem_block_adapter
  import mem_adapter_pkg::*;
#(
  parameter int unsigned WORD_SIZE        = WORD_SIZE_DEF,
  parameter int unsigned BLOCK_OFFSET     = BLOCK_OFFSET_DEF,
  parameter int unsigned BLOCK_DATA_WIDTH = WORD_SIZE << BLOCK_OFFSET
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WORD_SIZE-1:0]        cache_req_addr,
  input  logic                        cache_req_rw,
  input  logic                        cache_req_enable,
  input  logic [BLOCK_DATA_WIDTH-1:0] cache_req_wdata,
  output logic                        cache_res_ready,
  output logic [BLOCK_DATA_WIDTH-1:0] cache_res_rdata,
  output logic                        busy,
  output logic [WORD_SIZE-1:0]        mem_addr,
  output logic [WORD_SIZE-1:0]        mem_wdata,
  output logic                        mem_we,
  output logic                        mem_valid,
  input  logic                        mem_ack,
  input  logic [WORD_SIZE-1:0]        mem_rdata
);

  localparam int unsigned          WORDS    = 32'd1 << BLOCK_OFFSET;
  localparam logic [WORD_SIZE-1:0] OFF_MASK = WORD_SIZE'(WORDS - 32'd1);

  typedef logic [WORDS-1:0][WORD_SIZE-1:0] block_words_t;

  state_e                      state_q, state_d;
  logic                        busy_d, valid_d, we_d, ready_d;
  logic [WORD_SIZE-1:0]        addr_d, wdata_d, base_q, base_d;
  logic [BLOCK_DATA_WIDTH-1:0] rdata_d;
  block_words_t                in_words, wdata_q, asm_q, asm_next_c;
  logic                        cnt_load, cnt_inc, last_c;
  logic [BLOCK_OFFSET-1:0]     start_off_c, off_q, off_inc_c;

  assign in_words  = cache_req_wdata;
  assign off_inc_c = off_q + BLOCK_OFFSET'(1);

  // First word of a burst; write-backs always begin at word 0.
`ifdef MEM_CRITICAL_WORD_FIRST_EN
  assign start_off_c = cache_req_rw ? '0 : cache_req_addr[BLOCK_OFFSET-1:0];
`else
  assign start_off_c = '0;
`endif

  mem_beat_counter #(
    .OFFSET_W (BLOCK_OFFSET)
  ) u_beat_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .start_off (start_off_c),
    .inc       (cnt_inc),
    .offset    (off_q),
    .last_c    (last_c)
  );

  // Refill assembly: acked read data lands in the slot of its offset.
  always_comb begin
    asm_next_c = asm_q;
    if (state_q == RD_BURST && mem_ack) begin
      asm_next_c[off_q] = mem_rdata;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy;
    valid_d  = mem_valid;
    we_d     = mem_we;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    ready_d  = 1'b0;
    rdata_d  = cache_res_rdata;
    base_d   = base_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cache_req_enable) begin
          base_d   = cache_req_addr & ~OFF_MASK;
          cnt_load = 1'b1;
          busy_d   = 1'b1;
          valid_d  = 1'b1;
          we_d     = cache_req_rw;
          addr_d   = base_d | WORD_SIZE'(start_off_c);
          wdata_d  = cache_req_rw ? in_words[start_off_c] : '0;
          state_d  = cache_req_rw ? WR_BURST : RD_BURST;
        end
      end
      WR_BURST, RD_BURST: begin
        if (mem_ack) begin
          cnt_inc = 1'b1;
          if (last_c) begin
            state_d = DONE;
            valid_d = 1'b0;
            we_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
            ready_d = 1'b1;
            if (state_q == RD_BURST) begin
              rdata_d = asm_next_c;
            end
          end else begin
            addr_d  = base_q | WORD_SIZE'(off_inc_c);
            wdata_d = (state_q == WR_BURST) ? wdata_q[off_inc_c] : '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and request/assembly storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy            <= 1'b0;
      mem_valid       <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      cache_res_ready <= 1'b0;
      cache_res_rdata <= '0;
      base_q          <= '0;
      wdata_q         <= '0;
      asm_q           <= '0;
    end else begin
      busy            <= busy_d;
      mem_valid       <= valid_d;
      mem_we          <= we_d;
      mem_addr        <= addr_d;
      mem_wdata       <= wdata_d;
      cache_res_ready <= ready_d;
      cache_res_rdata <= rdata_d;
      base_q          <= base_d;
      asm_q           <= asm_next_c;
      if (state_q == IDLE && cache_req_enable) begin
        wdata_q <= in_words;
      end
    end
  end

endmodule

// File: tb/tb_mem_block_adapter.sv
// Directed bench for mem_block_adapter with a beat scoreboard and memory model.
module tb_mem_block_adapter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  cache_req_addr;
  logic         cache_req_rw;
  logic         cache_req_enable;
  logic [511:0] cache_req_wdata;
  logic         cache_res_ready;
  logic [511:0] cache_res_rdata;
  logic         busy;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_we;
  logic         mem_valid;
  logic         mem_ack = 1'b1;
  logic [31:0]  mem_rdata = 32'd0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } beat_t;

  beat_t sb[$];

  int total = 0;
  int bad = 0;
  int beats_seen = 0;
  int stall_beat = -1;
  int stall_left = 0;
  int ready_cnt = 0;
  bit stall_active = 1'b0;
  logic [31:0] held_addr, held_wdata;

  mem_block_adapter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cache_req_addr   (cache_req_addr),
    .cache_req_rw     (cache_req_rw),
    .cache_req_enable (cache_req_enable),
    .cache_req_wdata  (cache_req_wdata),
    .cache_res_ready  (cache_res_ready),
    .cache_res_rdata  (cache_res_rdata),
    .busy             (busy),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_we           (mem_we),
    .mem_valid        (mem_valid),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk_blk(input logic [31:0] b);
    logic [511:0] blk;
    for (int k = 0; k < 16; k++) blk[32*k +: 32] = b + 32'(k);
    return blk;
  endfunction

  // Expected beat order for one request, in the order memory should see it.
  task automatic push_beats(input logic [31:0] addr, input logic rw, input logic [511:0] wdata);
    beat_t e;
    logic [3:0] start;
    logic [3:0] off;
`ifdef MEM_CRITICAL_WORD_FIRST_EN
    start = rw ? 4'd0 : addr[3:0];
`else
    start = 4'd0;
`endif
    for (int i = 0; i < 16; i++) begin
      off     = start + 4'(i);
      e.addr  = (addr & ~32'hF) | {28'd0, off};
      e.wdata = wdata[32*off +: 32];
      e.we    = rw;
      sb.push_back(e);
    end
  endtask

  // Memory model: acks every presented beat unless stalling, checks each beat.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      mem_ack      = 1'b1;
      beats_seen   = 0;
      stall_active = 1'b0;
    end else if (mem_valid) begin
      if (stall_left > 0 && beats_seen == stall_beat) begin
        if (!stall_active) begin
          held_addr    = mem_addr;
          held_wdata   = mem_wdata;
          stall_active = 1'b1;
        end else begin
          check("stall_addr_hold", mem_addr, held_addr);
          check("stall_wdata_hold", mem_wdata, held_wdata);
        end
        mem_ack = 1'b0;
        stall_left--;
      end else begin
        if (stall_active) begin
          check("stall_addr_release", mem_addr, held_addr);
          check("stall_wdata_release", mem_wdata, held_wdata);
          stall_active = 1'b0;
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hC0DE0000 + mem_addr;
        check("beat_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("beat_addr", mem_addr, e.addr);
          check("beat_we", mem_we, e.we);
          if (e.we) check("beat_wdata", mem_wdata, e.wdata);
        end
        beats_seen++;
      end
    end else begin
      mem_ack = 1'b1;
    end
    if (cache_res_ready) ready_cnt++;
  end

  // One block transfer from the cache side; optionally pokes enable while busy.
  task automatic run_req(input logic [31:0] addr, input logic rw, input logic [511:0] wdata,
                         input int exp_lat, input int intrude_cyc, input bit en_at_done,
                         input logic [511:0] exp_rdata, input string tag);
    int n;
    push_beats(addr, rw, wdata);
    beats_seen       = 0;
    cache_req_addr   = addr;
    cache_req_rw     = rw;
    cache_req_wdata  = wdata;
    cache_req_enable = 1'b1;
    @(negedge clk);
    cache_req_enable = 1'b0;
    n = 1;
    check({tag, "_busy_after_accept"}, busy, 1'b1);
    while (!cache_res_ready && n < 100) begin
      @(negedge clk);
      n++;
      if (n == intrude_cyc) begin
        cache_req_addr   = 32'h40;
        cache_req_rw     = 1'b1;
        cache_req_enable = 1'b1;
      end else begin
        cache_req_enable = 1'b0;
      end
    end
    check({tag, "_latency"}, n + 1, exp_lat);
    check({tag, "_busy_at_ready"}, busy, 1'b1);
    check({tag, "_rdata"}, cache_res_rdata, exp_rdata);
    if (en_at_done) begin
      cache_req_addr   = 32'h40;
      cache_req_rw     = 1'b1;
      cache_req_enable = 1'b1;
    end
    @(negedge clk);
    cache_req_enable = 1'b0;
    check({tag, "_ready_one_cycle"}, cache_res_ready, 1'b0);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_all_beats"}, sb.size(), 0);
  endtask

  initial begin
    logic [511:0] blk_a, blk_b, exp20, exp60;
    int r0, n;
    rst_n            = 1'b0;
    cache_req_addr   = '0;
    cache_req_rw     = 1'b0;
    cache_req_enable = 1'b0;
    cache_req_wdata  = '0;
    blk_a = mk_blk(32'hA0000000);
    blk_b = mk_blk(32'hB0000000);
    exp20 = mk_blk(32'hC0DE0020);
    exp60 = mk_blk(32'hC0DE0060);

    repeat (3) @(negedge clk);
    check("rst_valid", mem_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", cache_res_ready, 1'b0);
    check("rst_rdata", cache_res_rdata, '0);
    check("rst_addr", mem_addr, '0);
    check("rst_we", mem_we, 1'b0);
    check("rst_wdata", mem_wdata, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write-back from an unaligned address; read data must stay untouched.
    run_req(32'h00000013, 1'b1, blk_a, 18, 0, 1'b0, '0, "wb");

    // Refill with memory returning 0xC0DE0000 + address.
    run_req(32'h00000020, 1'b0, '0, 18, 0, 1'b0, exp20, "rf");

    // Write with three stalled cycles on beat 5.
    stall_beat = 5;
    stall_left = 3;
    run_req(32'h00000100, 1'b1, blk_b, 21, 0, 1'b0, exp20, "bp");
    check("bp_stall_used", stall_left, 0);
    stall_beat = -1;

    // Enable mid-refill and again during the ready pulse: both ignored.
    r0 = ready_cnt;
    run_req(32'h00000060, 1'b0, '0, 18, 6, 1'b1, exp60, "ib");
    @(negedge clk);
    check("ib_still_idle", busy, 1'b0);
    check("ib_one_ready", ready_cnt - r0, 1);

    // Reset in the middle of a refill.
    r0 = ready_cnt;
    push_beats(32'h00000020, 1'b0, '0);
    beats_seen       = 0;
    cache_req_addr   = 32'h00000020;
    cache_req_rw     = 1'b0;
    cache_req_enable = 1'b1;
    @(negedge clk);
    cache_req_enable = 1'b0;
    n = 0;
    while (beats_seen < 7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rr_reached_beat7", n < 100, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rr_valid", mem_valid, 1'b0);
    check("rr_busy", busy, 1'b0);
    check("rr_ready", cache_res_ready, 1'b0);
    check("rr_rdata", cache_res_rdata, '0);
    check("rr_addr", mem_addr, '0);
    check("rr_we", mem_we, 1'b0);
    check("rr_wdata", mem_wdata, '0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rr_no_ready", ready_cnt, r0);
    run_req(32'h00000020, 1'b0, '0, 18, 0, 1'b0, exp20, "rr_refill");
    check("rr_one_ready", ready_cnt - r0, 1);

    // Unaligned refill; placement by offset regardless of beat order.
    run_req(32'h0000002D, 1'b0, '0, 18, 0, 1'b0, exp20, "cwf");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
